// File: rtl/gamepad_poller_pkg.sv
// Shared definitions for the serial gamepad poller: FSM states and
// button bit positions in the shifted word for SNES and NES pads.
package gamepad_poller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT_LO,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } state_t;

  localparam int unsigned SNES_B      = 0;
  localparam int unsigned SNES_Y      = 1;
  localparam int unsigned SNES_SELECT = 2;
  localparam int unsigned SNES_START  = 3;
  localparam int unsigned SNES_UP     = 4;
  localparam int unsigned SNES_DOWN   = 5;
  localparam int unsigned SNES_LEFT   = 6;
  localparam int unsigned SNES_RIGHT  = 7;
  localparam int unsigned SNES_A      = 8;
  localparam int unsigned SNES_X      = 9;
  localparam int unsigned SNES_L      = 10;
  localparam int unsigned SNES_R      = 11;

  localparam int unsigned NES_A      = 0;
  localparam int unsigned NES_B      = 1;
  localparam int unsigned NES_SELECT = 2;
  localparam int unsigned NES_START  = 3;
  localparam int unsigned NES_UP     = 4;
  localparam int unsigned NES_DOWN   = 5;
  localparam int unsigned NES_LEFT   = 6;
  localparam int unsigned NES_RIGHT  = 7;

endpackage

// File: rtl/joy_sync.sv
// Two-flop synchroniser for the asynchronous pad data lines.
module joy_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gamepad_poller.sv
// Periodic NES/SNES shift-register pad reader: strobes the pads, clocks out
// BITS bits per port and publishes active-high button words once per poll.
module gamepad_poller
  import gamepad_poller_pkg::*;
#(
  parameter int unsigned POLL_DIV   = 69905,
  parameter int unsigned STROBE_CYC = 25,
  parameter int unsigned HALF_CYC   = 12,
  parameter int unsigned BITS       = 16,
  parameter int unsigned PORTS      = 1,
  parameter bit          SNES_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  poll_now,
  input  logic [PORTS-1:0]      joy_data,
  output logic                  joy_strobe,
  output logic                  joy_clock,
  output logic [PORTS*BITS-1:0] buttons,
  output logic [PORTS-1:0]      connected,
  output logic                  valid,
  output logic                  busy
);

  localparam int unsigned DW   = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned TMAX = (STROBE_CYC > HALF_CYC) ? STROBE_CYC : HALF_CYC;
  localparam int unsigned TW   = $clog2(TMAX);
  localparam int unsigned BW   = $clog2(BITS);

  state_t                     state, state_next;
  logic [DW-1:0]              div;
  logic [TW-1:0]              timer;
  logic [BW-1:0]              bit_idx;
  logic                       pending;
  logic [PORTS-1:0]           data_s;
  logic [PORTS*(BITS-1)-1:0]  hist, hist_next;
  logic [PORTS*BITS-1:0]      word, pressed;
  logic [PORTS-1:0]           present;
  logic                       tick, strobe_last, half_last, sample, last_bit, start;

  joy_sync #(.WIDTH(PORTS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (joy_data),
    .q     (data_s)
  );

  function automatic logic pad_present(input logic [BITS-1:0] raw);
    logic [31:0] wide;
    wide = 32'(raw);
    return (raw != '0) && (!SNES_CHECK || BITS != 16 || wide[15:12] == 4'hF);
  endfunction

  assign tick        = (div == DW'(POLL_DIV - 1));
  assign strobe_last = (timer == TW'(STROBE_CYC - 1));
  assign half_last   = (timer == TW'(HALF_CYC - 1));
  assign sample      = half_last && (state == ST_WAIT_LO || state == ST_CLK_HI);
  assign last_bit    = (bit_idx == BW'(BITS - 1));
  assign start       = (state == ST_IDLE || state == ST_DONE) && (tick || poll_now || pending);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:               if (start) state_next = ST_STROBE;
      ST_STROBE:             if (strobe_last) state_next = ST_WAIT_LO;
      ST_WAIT_LO, ST_CLK_HI: if (half_last) state_next = last_bit ? ST_DONE : ST_CLK_LO;
      ST_CLK_LO:             if (half_last) state_next = ST_CLK_HI;
      ST_DONE:               state_next = start ? ST_STROBE : ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    joy_strobe = (state == ST_STROBE);
    joy_clock  = (state != ST_CLK_LO);
    valid      = (state == ST_DONE);
    busy       = (state != ST_IDLE);
  end

  // The word including the bit being sampled this cycle, so the final sample
  // can be published on the same edge that enters DONE.
  always_comb begin
    word      = '0;
    hist_next = '0;
    present   = '0;
    pressed   = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      word[p*BITS +: BITS]           = {data_s[p], hist[p*(BITS-1) +: BITS-1]};
      hist_next[p*(BITS-1) +: BITS-1] = word[p*BITS+1 +: BITS-1];
      present[p]                     = pad_present(word[p*BITS +: BITS]);
      pressed[p*BITS +: BITS]        = present[p] ? ~word[p*BITS +: BITS] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div       <= '0;
      timer     <= '0;
      bit_idx   <= '0;
      pending   <= 1'b0;
      hist      <= '0;
      buttons   <= '0;
      connected <= '0;
    end else begin
      div   <= tick ? '0 : div + 1'b1;
      timer <= (state_next != state) ? '0 : timer + 1'b1;
      if (start)                       pending <= 1'b0;
      else if ((tick || poll_now) && busy) pending <= 1'b1;
      if (state == ST_STROBE) bit_idx <= '0;
      else if (sample)        bit_idx <= bit_idx + 1'b1;
      if (sample) hist <= hist_next;
      if (sample && last_bit) begin
        buttons   <= pressed;
        connected <= present;
      end
    end
  end

endmodule

// File: tb/tb_gamepad_poller.sv
// Bench for gamepad_poller: an 8-bit single-port instance for timing, glitch
// and reset-abort cases, and a 16-bit two-port SNES instance for decoding.
module tb_gamepad_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset8, poll_now8, joy_strobe8, joy_clock8, valid8, busy8;
  logic [0:0] joy_data8, connected8;
  logic [7:0] buttons8;
  logic        reset16, poll_now16, joy_strobe16, joy_clock16, valid16, busy16;
  logic [1:0]  joy_data16, connected16;
  logic [31:0] buttons16;

  gamepad_poller #(.POLL_DIV(200), .STROBE_CYC(4), .HALF_CYC(3), .BITS(8), .PORTS(1),
                   .SNES_CHECK(1)) dut8 (
    .clk(clk), .reset(reset8), .poll_now(poll_now8), .joy_data(joy_data8),
    .joy_strobe(joy_strobe8), .joy_clock(joy_clock8), .buttons(buttons8),
    .connected(connected8), .valid(valid8), .busy(busy8));

  gamepad_poller #(.POLL_DIV(400), .STROBE_CYC(4), .HALF_CYC(3), .BITS(16), .PORTS(2),
                   .SNES_CHECK(1)) dut16 (
    .clk(clk), .reset(reset16), .poll_now(poll_now16), .joy_data(joy_data16),
    .joy_strobe(joy_strobe16), .joy_clock(joy_clock16), .buttons(buttons16),
    .connected(connected16), .valid(valid16), .busy(busy16));

  // Pad models: latch on strobe, advance one bit per rising shift clock.
  logic [7:0]  raw8;
  logic [15:0] raw16a, raw16b;
  logic        glitch8 = 1'b0;
  int idx8 = 0, idx16 = 0;
  always @(posedge joy_strobe8 or posedge joy_clock8) begin
    #1;
    if (joy_strobe8) idx8 = 0;
    else if (idx8 < 7) idx8 = idx8 + 1;
  end
  always @(posedge joy_strobe16 or posedge joy_clock16) begin
    #1;
    if (joy_strobe16) idx16 = 0;
    else if (idx16 < 15) idx16 = idx16 + 1;
  end
  assign joy_data8[0] = raw8[idx8] ^ glitch8;
  assign joy_data16   = {raw16b[idx16], raw16a[idx16]};

  typedef struct {
    logic [15:0] raw0, raw1;
    logic [1:0]  conn;
    logic [15:0] btn0, btn1;
  } vec_t;
  vec_t tbl[5];

  int total = 0, bad = 0, v8_cnt = 0, v16_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (valid8 === 1'b1) v8_cnt++;
    if (valid16 === 1'b1) v16_cnt++;
  endtask

  task automatic wait_to(input int c);
    if (cyc > c) check("late_wait", cyc, c);
    while (cyc < c) step();
  endtask

  task automatic pulse8();
    poll_now8 = 1'b1; step(); poll_now8 = 1'b0;
  endtask

  task automatic pulse16();
    poll_now16 = 1'b1; step(); poll_now16 = 1'b0;
  endtask

  // SNES rule: present if any line high and the four unused bits read high.
  function automatic logic [16:0] ref16(input logic [15:0] raw);
    logic c;
    c = (raw != 16'h0) && (raw[15:12] == 4'hF);
    return {c, c ? ~raw : 16'h0};
  endfunction

  initial begin
    int r, r1, t8, c1, c2, t16, c, vb, first_s, last_s, s_n, lo_n, fall_n, vcyc, holdbad;
    logic prev_c;
    vec_t cur;
    logic [15:0] x0, x1;
    logic [16:0] e0, e1;

    tbl[0] = '{16'hF0FE, 16'hFFFF, 2'b11, 16'h0F01, 16'h0000};
    tbl[1] = '{16'h70FE, 16'hFFFF, 2'b10, 16'h0000, 16'h0000};
    tbl[2] = '{16'h0000, 16'hFFFF, 2'b10, 16'h0000, 16'h0000};
    tbl[3] = '{16'hFFFF, 16'h0000, 2'b01, 16'h0000, 16'h0000};
    tbl[4] = '{16'hF123, 16'hF000, 2'b11, 16'h0EDC, 16'h0FFF};

    reset8 = 1'b1; reset16 = 1'b1; poll_now8 = 1'b0; poll_now16 = 1'b0;
    raw8 = 8'h5A; raw16a = 16'hF0FE; raw16b = 16'hFFFF;
    wait_to(3);
    check("rst_strobe", joy_strobe8, 0);
    check("rst_clock", joy_clock8, 1);
    check("rst_buttons", buttons8, 0);
    check("rst_conn", connected8, 0);
    check("rst_valid_busy", {valid8, busy8}, 0);
    check("rst16_outs", {joy_strobe16, joy_clock16, connected16, valid16, busy16}, 6'b010000);
    reset8 = 1'b0; reset16 = 1'b0;
    r = cyc;

    // Automatic poll: timing of strobe, shift clock and valid.
    t8 = r + 199;
    wait_to(t8);
    check("idle_before_tick", busy8, 0);
    first_s = -1; last_s = -1; s_n = 0; lo_n = 0; fall_n = 0; vcyc = -1; prev_c = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (joy_strobe8) begin
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
        s_n++;
      end
      if (!joy_clock8) lo_n++;
      if (prev_c && !joy_clock8) fall_n++;
      prev_c = joy_clock8;
      if (valid8 && vcyc < 0) vcyc = cyc;
    end
    check("strobe_first", first_s, t8 + 1);
    check("strobe_last", last_s, t8 + 4);
    check("strobe_len", s_n, 4);
    check("clk_low_cycles", lo_n, 21);
    check("clk_pulses", fall_n, 7);
    check("valid_latency", vcyc, t8 + 50);
    check("buttons_5A", buttons8, 8'hA5);
    check("conn_5A", connected8, 1);
    check("valid_count8", v8_cnt, 1);
    step();
    check("valid_one_cycle", valid8, 0);
    check("busy_drop", busy8, 0);

    // Forced poll with a one-cycle data glitch between sample points.
    raw8 = 8'h3C;
    c1 = r + 260;
    wait_to(c1);
    pulse8();
    holdbad = 0;
    while (cyc < c1 + 50) begin
      glitch8 = (cyc == c1 + 20);
      step();
      if (cyc < c1 + 50 && buttons8 !== 8'hA5) holdbad++;
    end
    glitch8 = 1'b0;
    check("hold_during_poll", holdbad, 0);
    check("pollnow_valid", valid8, 1);
    check("glitch_buttons", buttons8, 8'hC3);
    check("glitch_conn", connected8, 1);

    // Reset during the low phase before bit 5 aborts without publishing.
    raw8 = 8'h81;
    c2 = r + 320;
    wait_to(c2);
    vb = v8_cnt;
    pulse8();
    wait_to(c2 + 33);
    check("in_clk_lo", {joy_clock8, busy8}, 2'b01);
    reset8 = 1'b1;
    step();
    check("abort_clock", joy_clock8, 1);
    check("abort_strobe", joy_strobe8, 0);
    check("abort_buttons", buttons8, 0);
    check("abort_conn", connected8, 0);
    check("abort_busy_valid", {busy8, valid8}, 0);
    reset8 = 1'b0;
    r1 = cyc;
    wait_to(r1 + 5);
    pulse8();
    wait_to(r1 + 55);
    check("post_reset_valid", valid8, 1);
    check("no_partial_publish", v8_cnt - vb, 1);
    check("post_reset_buttons", buttons8, 8'h7E);
    check("post_reset_conn", connected8, 1);

    // Two-port SNES decoding: table entries then random words.
    for (int i = 0; i < 11; i++) begin
      t16 = r + (i + 2) * 400 - 1;
      wait_to(t16 - 100);
      if (i < 5) cur = tbl[i];
      else begin
        x0 = 16'($urandom);
        x1 = 16'($urandom);
        if ($urandom_range(3, 0) != 0) x0[15:12] = 4'hF;
        if ($urandom_range(3, 0) != 0) x1[15:12] = 4'hF;
        e0 = ref16(x0);
        e1 = ref16(x1);
        cur = '{x0, x1, {e1[16], e0[16]}, e0[15:0], e1[15:0]};
      end
      raw16a = cur.raw0;
      raw16b = cur.raw1;
      wait_to(t16);
      vb = v16_cnt;
      wait_to(t16 + 98);
      check($sformatf("v16_at_latency_%0d", i), valid16, 1);
      check($sformatf("v16_single_%0d", i), v16_cnt - vb, 1);
      check($sformatf("conn16_%0d", i), connected16, cur.conn);
      check($sformatf("btn16_%0d", i), buttons16, {cur.btn1, cur.btn0});
      step();
      check($sformatf("v16_low_after_%0d", i), valid16, 0);
    end

    // Requests during a busy poll merge into one follow-up poll.
    t16 = r + 13 * 400 - 1;
    c = t16 - 52;
    wait_to(c);
    vb = v16_cnt;
    pulse16();
    wait_to(t16);
    pulse16();
    wait_to(t16 + 20);
    pulse16();
    wait_to(c + 98);
    check("pend_first_done", valid16, 1);
    step();
    check("pend_restart", {joy_strobe16, busy16}, 2'b11);
    wait_to(c + 196);
    check("pend_second_done", valid16, 1);
    step();
    check("idle_after_pending", busy16, 0);
    wait_to(t16 + 300);
    check("pend_valid_pulses", v16_cnt - vb, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
